// File: rtl/alu_sel_pkg.sv
// Shared constants for the ALU operand-select block: Y86-64 instruction
// codes, ALU function codes and the stack-pointer adjustment constants.
package alu_sel_pkg;

   localparam int DATA_W = 64;

   // Y86-64 instruction codes
   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] I_IADDQ  = 4'hC;

   // ALU function codes
   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_AND = 2'd2;
   localparam logic [1:0] ALU_XOR = 2'd3;

   // Stack pointer adjustments: pop/ret grow by 8, push/call shrink by 8
   localparam logic [DATA_W-1:0] K_PLUS8  = 64'h0000_0000_0000_0008;
   localparam logic [DATA_W-1:0] K_MINUS8 = 64'hFFFF_FFFF_FFFF_FFF8;

endpackage

// File: rtl/alu_sel_decode.sv
// Combinational operand/function selection for the Y86-64 execute stage.
// Optional feature macro: ALU_SEL_IADDQ_EN (adds iaddq, icode 0xC).
module alu_sel_decode
   import alu_sel_pkg::*;
(
   input  logic [3:0]        icode,
   input  logic [3:0]        ifun,
   input  logic [DATA_W-1:0] val_a,
   input  logic [DATA_W-1:0] val_b,
   input  logic [DATA_W-1:0] val_c,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alufun,
   output logic              sel_err
);

   // Select operands per instruction; unsupported encodings force all-zero operands
   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alufun  = ALU_ADD;
      sel_err = 1'b0;
      case (icode)
         I_HALT, I_NOP, I_JXX: begin
            alu_a = '0;
         end
         I_RRMOVQ: begin
            alu_a = val_a;
         end
         I_IRMOVQ: begin
            alu_a = val_c;
         end
         I_RMMOVQ, I_MRMOVQ: begin
            alu_a = val_c;
            alu_b = val_b;
         end
         I_OPQ: begin
            if (ifun > {2'b00, ALU_XOR}) begin
               sel_err = 1'b1;
            end else begin
               alu_a  = val_a;
               alu_b  = val_b;
               alufun = ifun[1:0];
            end
         end
         I_CALL, I_PUSHQ: begin
            alu_a = K_MINUS8;
            alu_b = val_b;
         end
         I_RET, I_POPQ: begin
            alu_a = K_PLUS8;
            alu_b = val_b;
         end
`ifdef ALU_SEL_IADDQ_EN
         I_IADDQ: begin
            alu_a = val_c;
            alu_b = val_b;
         end
`endif
         default: begin
            sel_err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_operand_select.sv
// ALU operand select: one-cycle registered wrapper around alu_sel_decode.
// Outputs hold their last result while in_valid is low; out_valid tracks
// in_valid with one cycle of latency.
// Optional feature macro: ALU_SEL_IADDQ_EN (adds iaddq, icode 0xC).
module alu_operand_select
   import alu_sel_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [3:0]        icode,
   input  logic [3:0]        ifun,
   input  logic [DATA_W-1:0] valA,
   input  logic [DATA_W-1:0] valB,
   input  logic [DATA_W-1:0] valC,
   output logic              out_valid,
   output logic [DATA_W-1:0] aluA,
   output logic [DATA_W-1:0] aluB,
   output logic [1:0]        alufun,
   output logic              sel_err
);

   logic [DATA_W-1:0] dec_alu_a;
   logic [DATA_W-1:0] dec_alu_b;
   logic [1:0]        dec_alufun;
   logic              dec_sel_err;

   logic              out_valid_d, out_valid_q;
   logic [DATA_W-1:0] alu_a_d, alu_a_q;
   logic [DATA_W-1:0] alu_b_d, alu_b_q;
   logic [1:0]        alufun_d, alufun_q;
   logic              sel_err_d, sel_err_q;

   alu_sel_decode u_decode (
      .icode   (icode),
      .ifun    (ifun),
      .val_a   (valA),
      .val_b   (valB),
      .val_c   (valC),
      .alu_a   (dec_alu_a),
      .alu_b   (dec_alu_b),
      .alufun  (dec_alufun),
      .sel_err (dec_sel_err)
   );

   // Capture a new result only on valid input; otherwise keep the last one
   always_comb begin
      out_valid_d = in_valid;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alufun_d    = alufun_q;
      sel_err_d   = sel_err_q;
      if (in_valid) begin
         alu_a_d   = dec_alu_a;
         alu_b_d   = dec_alu_b;
         alufun_d  = dec_alufun;
         sel_err_d = dec_sel_err;
      end
   end

   // Output registers; reset clears everything, discarding any in-flight result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alufun_q    <= ALU_ADD;
         sel_err_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alufun_q    <= alufun_d;
         sel_err_q   <= sel_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign aluA      = alu_a_q;
   assign aluB      = alu_b_q;
   assign alufun    = alufun_q;
   assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_alu_operand_select.sv
// Testbench for alu_operand_select: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
// Honors ALU_SEL_IADDQ_EN the same way the design does.
module tb_alu_operand_select;

`ifdef ALU_SEL_IADDQ_EN
   localparam bit IADDQ_EN = 1'b1;
`else
   localparam bit IADDQ_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic [63:0] valA, valB, valC;
   logic        out_valid;
   logic [63:0] aluA, aluB;
   logic [1:0]  alufun;
   logic        sel_err;

   int n_checks = 0;
   int n_fail   = 0;

   // expected registered state
   logic        exp_v;
   logic [63:0] exp_a, exp_b;
   logic [1:0]  exp_fn;
   logic        exp_err;

   alu_operand_select dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .icode     (icode),
      .ifun      (ifun),
      .valA      (valA),
      .valB      (valB),
      .valC      (valC),
      .out_valid (out_valid),
      .aluA      (aluA),
      .aluB      (aluB),
      .alufun    (alufun),
      .sel_err   (sel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: the selection rules stated as set membership
   function automatic void ref_sel(input logic [3:0] ic, input logic [3:0] fn,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] c,
                                   output logic [63:0] ra, output logic [63:0] rb,
                                   output logic [1:0] rf, output logic re);
      bit supported;
      supported = (ic <= 4'hB) || (IADDQ_EN && ic == 4'hC);
      re = !supported || (ic == 4'h6 && fn > 4'd3);
      ra = 64'd0;
      rb = 64'd0;
      rf = 2'd0;
      if (!re) begin
         if (ic inside {4'h2, 4'h6})               ra = a;
         else if (ic inside {4'h3, 4'h4, 4'h5, 4'hC}) ra = c;
         else if (ic inside {4'h8, 4'hA})          ra = 64'd0 - 64'd8;
         else if (ic inside {4'h9, 4'hB})          ra = 64'd8;
         if (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC}) rb = b;
         if (ic == 4'h6) rf = fn[1:0];
      end
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, exp_v});
      chk({tag, ".aluA"},      aluA,               exp_a);
      chk({tag, ".aluB"},      aluB,               exp_b);
      chk({tag, ".alufun"},    {62'd0, alufun},    {62'd0, exp_fn});
      chk({tag, ".sel_err"},   {63'd0, sel_err},   {63'd0, exp_err});
   endtask

   // Drive one cycle of input (called just after a falling edge), update the
   // model at the rising edge, compare at the following falling edge.
   task automatic step(input string tag, input logic v, input logic [3:0] ic,
                       input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c);
      logic [63:0] ra, rb;
      logic [1:0]  rf;
      logic        re;
      in_valid = v;
      icode    = ic;
      ifun     = fn;
      valA     = a;
      valB     = b;
      valC     = c;
      @(posedge clk);
      exp_v = v;
      if (v) begin
         ref_sel(ic, fn, a, b, c, ra, rb, rf, re);
         exp_a   = ra;
         exp_b   = rb;
         exp_fn  = rf;
         exp_err = re;
      end
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic model_reset();
      exp_v   = 1'b0;
      exp_a   = 64'd0;
      exp_b   = 64'd0;
      exp_fn  = 2'd0;
      exp_err = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      icode    = 4'h0;
      ifun     = 4'h0;
      valA     = 64'd0;
      valB     = 64'd0;
      valC     = 64'd0;
      model_reset();

      // reset state, before any clock edge
      #2;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // OPq SUB
      step("opq", 1'b1, 4'h6, 4'h1, 64'd5, 64'd9, 64'd0);
      chk("opq.aluA_lit", aluA, 64'd5);
      chk("opq.aluB_lit", aluB, 64'd9);
      chk("opq.fn_lit", {62'd0, alufun}, 64'd1);

      // stack ops
      step("pushq", 1'b1, 4'hA, 4'h0, 64'd3, 64'h100, 64'd0);
      chk("pushq.aluA_lit", aluA, 64'hFFFF_FFFF_FFFF_FFF8);
      step("ret", 1'b1, 4'h9, 4'h0, 64'd3, 64'hF8, 64'd0);
      chk("ret.aluA_lit", aluA, 64'd8);
      chk("ret.aluB_lit", aluB, 64'hF8);

      // moves
      step("irmovq", 1'b1, 4'h3, 4'h0, 64'd11, 64'd22, 64'h1234);
      chk("irmovq.aluA_lit", aluA, 64'h1234);
      chk("irmovq.aluB_lit", aluB, 64'd0);
      step("rrmovq", 1'b1, 4'h2, 4'h0, 64'd7, 64'd22, 64'h55);
      chk("rrmovq.aluA_lit", aluA, 64'd7);

      // errors
      step("opq_bad", 1'b1, 4'h6, 4'h5, 64'd5, 64'd9, 64'd1);
      chk("opq_bad.err_lit", {63'd0, sel_err}, 64'd1);
      chk("opq_bad.aluA_lit", aluA, 64'd0);
      step("iaddq", 1'b1, 4'hC, 4'h0, 64'd1, 64'hABC, 64'h77);
      if (IADDQ_EN) chk("iaddq.aluA_lit", aluA, 64'h77);
      else          chk("iaddq.err_lit", {63'd0, sel_err}, 64'd1);
      step("bad_icode", 1'b1, 4'hF, 4'h0, 64'd1, 64'd2, 64'd3);
      step("mrmovq", 1'b1, 4'h5, 4'h0, 64'hAA, 64'hBB, 64'hCC);

      // gap: out_valid drops, data holds
      step("gap", 1'b0, 4'h6, 4'h2, 64'd99, 64'd98, 64'd97);
      chk("gap.hold_lit", aluA, 64'hCC);
      step("after_gap", 1'b1, 4'h6, 4'h3, 64'hF0F0, 64'h0FF0, 64'd0);

      // reset mid-stream: asynchronous clear before the next edge
      in_valid = 1'b1;
      icode    = 4'h6;
      ifun     = 4'h2;
      valA     = 64'hDEAD;
      valB     = 64'hBEEF;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge clk);
      @(negedge clk);
      check_all("rst_held");
      rst_n = 1'b1;
      step("post_rst", 1'b1, 4'h8, 4'h0, 64'd1, 64'h2000, 64'd0);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         step("rand", ($urandom_range(0, 9) < 8),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_operand_select.md
ALU_OPERAND_SELECT -- requirements
Module: alu_operand_select

Interface
- REQ-001 SHALL have `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
- REQ-002 SHALL have `rst_n`: input, 1 bit, asynchronous active-low reset.
- REQ-003 SHALL have `in_valid`: input, 1 bit, high when icode/ifun/valA/valB/valC are valid this cycle.
- REQ-004 SHALL have `icode`: input, 4 bits, Y86-64 instruction code.
- REQ-005 SHALL have `ifun`: input, 4 bits, Y86-64 function code.
- REQ-006 SHALL have `valA`: input, 64 bits, decode-stage operand A.
- REQ-007 SHALL have `valB`: input, 64 bits, decode-stage operand B.
- REQ-008 SHALL have `valC`: input, 64 bits, instruction constant.
- REQ-009 SHALL have `out_valid`: output, 1 bit, high when the registered outputs hold a result.
- REQ-010 SHALL have `aluA`: output, 64 bits, ALU operand A.
- REQ-011 SHALL have `aluB`: output, 64 bits, ALU operand B.
- REQ-012 SHALL have `alufun`: output, 2 bits, ALU op: 0 ADD, 1 SUB, 2 AND, 3 XOR.
- REQ-013 SHALL have `sel_err`: output, 1 bit, high for an unsupported icode or OPq ifun.

Function
- REQ-014 Opcode set: 0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.
- REQ-015 aluA selection SHALL be:
  - valA for icode 2 and 6;
  - valC for icode 3, 4 and 5;
  - 0xFFFF_FFFF_FFFF_FFF8 (-8) for icode 8 and A;
  - 64'd8 for icode 9 and B;
  - 0 otherwise.
- REQ-016 aluB selection SHALL be:
  - valB for icode 4, 5, 6, 8, 9, A and B;
  - 0 for icode 2 and 3;
  - 0 otherwise.
- REQ-017 alufun SHALL be ifun[1:0] when icode is 6; otherwise it SHALL be 0 (ADD).
- REQ-018 sel_err SHALL be 1 in either case:
  - icode above 0xB (above 0xC when the REQ-025 feature is compiled in);
  - icode 6 with ifun above 3.
- REQ-019 When sel_err is 1, aluA, aluB and alufun SHALL all be 0.
- REQ-020 Latency SHALL be one cycle: inputs sampled while in_valid=1 appear on the outputs after the next rising edge, with out_valid=1.
- REQ-021 When in_valid=0 at a rising edge, out_valid SHALL go to 0 and aluA/aluB/alufun/sel_err SHALL hold their previous values.
- REQ-022 There SHALL be no backpressure: every valid input is accepted; back-to-back inputs produce back-to-back outputs.
- REQ-023 All arithmetic SHALL be 64-bit with no sign extension of inputs; the constants are exact 64-bit patterns.

Reset
- REQ-024 While rst_n=0, all outputs SHALL be 0 (out_valid, aluA, aluB, alufun, sel_err), immediately and without waiting for clk. The first capture SHALL be on the first rising edge after rst_n is released. Reset asserted mid-stream SHALL discard the in-flight result.

Configuration
- REQ-025 The macro `ALU_SEL_IADDQ_EN` SHALL control iaddq support (icode 0xC).
  - Defined: icode 0xC gives aluA=valC, aluB=valB, alufun=ADD, sel_err=0.
  - Undefined: icode 0xC is unsupported, giving sel_err=1 and zero outputs.

Structure
- REQ-026 A shared package `alu_sel_pkg` SHALL hold:
  - icode localparams (I_HALT..I_POPQ, I_IADDQ);
  - alufun localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR);
  - constants K_PLUS8 and K_MINUS8.
- REQ-027 The block SHALL contain one combinational sub-module, `alu_sel_decode`, implementing REQ-015 to REQ-019. The top level SHALL contain only that instance plus the output registers.

Verification
- REQ-028 The bench SHALL cover these directed scenarios:
  - OPq: icode=6, ifun=1, valA=5, valB=9 -> next cycle aluA=5, aluB=9, alufun=1, out_valid=1, sel_err=0.
  - Stack: icode=A, valB=0x100 -> aluA=0xFFFF_FFFF_FFFF_FFF8, aluB=0x100, alufun=0; then icode=9, valB=0xF8 -> aluA=8, aluB=0xF8.
  - Moves: icode=3, valC=0x1234 -> aluA=0x1234, aluB=0; then icode=2, valA=7 -> aluA=7, aluB=0.
  - Errors: icode=6, ifun=5 -> sel_err=1 with all outputs 0; icode=0xC -> sel_err=1 without ALU_SEL_IADDQ_EN, and aluA=valC, aluB=valB, sel_err=0 with it.
  - Reset and gaps: assert rst_n=0 mid-stream -> outputs 0 before the next clk edge; in_valid=0 for one cycle -> out_valid=0 while data holds.
